pe_sched: RTL and testbench
===========================

PE_SCHED -- requirements
Module: pe_sched

Interface
REQ-001 SHALL have parameter PE_LAT, default 8, meaning cycles from PE operand issue to PE result valid; legal range 4..15.
REQ-002 SHALL have parameter PH_W, default 5, meaning phase counter width; must hold 2*PE_LAT+3.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  in  1  one-cycle request to bidiagonalize the 4x4 tile buffer.
REQ-006 SHALL have port abort  in  1  cancel the in-flight sequence.
REQ-007 SHALL have port busy  out  1  sequence in progress.
REQ-008 SHALL have port done  out  1  one-cycle completion pulse.
REQ-009 SHALL have ports pe0_valid, pe1_valid  out  2  per-PE operand valid, 2'b11 on issue, else 2'b00.
REQ-010 SHALL have ports pe0_scheme, pe1_scheme  out  2  0 COMPLEX_2_REAL, 1 COMPLEX_ROTATE, 2 REAL_NULLIFIED, 3 RELATED_ROTATE.
REQ-011 SHALL have ports tile_row, tile_col  out  1 each  issued tile: rows {2*tile_row, +1}, PE0 column 2*tile_col, PE1 column 2*tile_col+1.
REQ-012 SHALL have port op_src  out  1  0 = operands from tile buffer, 1 = PE result feedback.
REQ-013 SHALL have port op_swap  out  1  feed the two rows to the PE in reversed order.
REQ-014 SHALL have ports wb_en, wb_row, wb_col, wb_swap  out  1 each  write PE results back to the tile at (wb_row, wb_col); wb_swap writes x1/y1 to the upper row.
REQ-015 SHALL have port phase  out  PH_W  current phase counter, for debug.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after phase 2*PE_LAT+3; DONE->IDLE unconditionally after one cycle.
REQ-017 SHALL clear phase to 0 on entering RUN and increment it by 1 each RUN cycle.
REQ-018 SHALL hold busy=1 exactly while in RUN; done=1 exactly while in DONE.
REQ-019 SHALL, at phase k=0..3, issue pass-1 tile t=k (tile_row=t[1], tile_col=t[0]) with op_src=0, op_swap=0, pe0_scheme=COMPLEX_2_REAL if tile_col=0 else COMPLEX_ROTATE, pe1_scheme=COMPLEX_ROTATE.
REQ-020 SHALL, at phase k=PE_LAT..PE_LAT+3, assert wb_en for tile t=k-PE_LAT with wb_swap=0, and in the same cycle issue pass-2 tile t with op_src=1, op_swap=tile_row, pe0_scheme=REAL_NULLIFIED if tile_col=0 else RELATED_ROTATE, pe1_scheme=RELATED_ROTATE.
REQ-021 SHALL, at phase k=2*PE_LAT..2*PE_LAT+3, assert wb_en for tile t=k-2*PE_LAT with wb_swap=tile_row, with no issue.
REQ-022 SHALL drive pe*_valid=0, scheme=0, op_src=0, op_swap=0, wb_en=0, wb_swap=0, tile/wb indices=0 in every cycle not listed above.
REQ-023 SHALL ignore start while in RUN or DONE.
REQ-024 SHALL, on abort in RUN, go to IDLE next cycle with all issue/write-back outputs 0 and no done pulse; abort in IDLE/DONE has no effect; abort wins over start in the same cycle.
REQ-025 SHALL make all outputs registered-state decodes; no combinational path from start or abort to any output.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, enter IDLE, phase=0, and force every output to 0 next cycle; rst overrides start and abort, including mid-RUN.

Structure
REQ-027 SHALL take scheme codes, state encoding and default PE_LAT from the shared package pe_pkg, also used by the PE array and top.
REQ-028 SHALL use one sub-module, pe_tile_decode (combinational: phase -> issue/write-back fields); sequential logic stays in pe_sched.

Verification
REQ-029 SHALL cover: PE_LAT=8, start at cycle 0 -> busy cycles 1-20, issue phases 0-3 and 8-11, wb_en phases 8-11 and 16-19, done at cycle 21.
REQ-030 SHALL cover: phase 10 -> tile_row=1, tile_col=0, op_src=1, op_swap=1, pe0_scheme=2, pe1_scheme=3, wb_en=1, wb_swap=0.
REQ-031 SHALL cover: phase 18 -> wb_row=1, wb_col=0, wb_swap=1, pe0_valid=pe1_valid=2'b00.
REQ-032 SHALL cover: start re-pulsed at phase 5 -> no restart, done still at cycle 21.
REQ-033 SHALL cover: abort at phase 9 -> IDLE next cycle, no done; new start runs a full clean sequence.
REQ-034 SHALL cover: rst at phase 12 -> all outputs 0 next cycle, busy=0; PE_LAT=4 run -> done at cycle 13.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared PE-array definitions: scheme codes, scheduler state encoding and default PE latency.
package pe_pkg;
   localparam int PE_LAT_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SCH_COMPLEX_2_REAL = 2'd0,
      SCH_COMPLEX_ROTATE = 2'd1,
      SCH_REAL_NULLIFIED = 2'd2,
      SCH_RELATED_ROTATE = 2'd3
   } scheme_t;
endpackage

// File: rtl/pe_tile_decode.sv
// Phase -> PE issue / write-back field decode for the 4x4 bidiagonalization sequence.
module pe_tile_decode
   import pe_pkg::*;
#(
   parameter int PE_LAT = PE_LAT_DEF,
   parameter int PH_W   = 5
) (
   input  logic            i_run,
   input  logic [PH_W-1:0] i_phase,
   output logic            o_issue,
   output logic [1:0]      o_pe0_scheme,
   output logic [1:0]      o_pe1_scheme,
   output logic            o_tile_row,
   output logic            o_tile_col,
   output logic            o_op_src,
   output logic            o_op_swap,
   output logic            o_wb_en,
   output logic            o_wb_row,
   output logic            o_wb_col,
   output logic            o_wb_swap
);
   localparam logic [PH_W-1:0] P1_HI = PH_W'(3);
   localparam logic [PH_W-1:0] P2_LO = PH_W'(PE_LAT);
   localparam logic [PH_W-1:0] P2_HI = PH_W'(PE_LAT + 3);
   localparam logic [PH_W-1:0] P3_LO = PH_W'(2 * PE_LAT);
   localparam logic [PH_W-1:0] P3_HI = PH_W'(2 * PE_LAT + 3);
   localparam logic [1:0]      LAT_LO  = 2'(PE_LAT);
   localparam logic [1:0]      LAT2_LO = 2'(2 * PE_LAT);

   // Tile index only needs the low two bits of (phase - offset).
   logic [1:0] w_t2;
   logic [1:0] w_t3;
   assign w_t2 = i_phase[1:0] - LAT_LO;
   assign w_t3 = i_phase[1:0] - LAT2_LO;

   always_comb begin
      o_issue      = 1'b0;
      o_pe0_scheme = SCH_COMPLEX_2_REAL;
      o_pe1_scheme = SCH_COMPLEX_2_REAL;
      o_tile_row   = 1'b0;
      o_tile_col   = 1'b0;
      o_op_src     = 1'b0;
      o_op_swap    = 1'b0;
      o_wb_en      = 1'b0;
      o_wb_row     = 1'b0;
      o_wb_col     = 1'b0;
      o_wb_swap    = 1'b0;
      if (i_run) begin
         if (i_phase <= P1_HI) begin
            o_issue      = 1'b1;
            o_tile_row   = i_phase[1];
            o_tile_col   = i_phase[0];
            o_pe0_scheme = i_phase[0] ? SCH_COMPLEX_ROTATE : SCH_COMPLEX_2_REAL;
            o_pe1_scheme = SCH_COMPLEX_ROTATE;
         end else if (i_phase >= P2_LO && i_phase <= P2_HI) begin
            o_wb_en      = 1'b1;
            o_wb_row     = w_t2[1];
            o_wb_col     = w_t2[0];
            o_issue      = 1'b1;
            o_tile_row   = w_t2[1];
            o_tile_col   = w_t2[0];
            o_op_src     = 1'b1;
            o_op_swap    = w_t2[1];
            o_pe0_scheme = w_t2[0] ? SCH_RELATED_ROTATE : SCH_REAL_NULLIFIED;
            o_pe1_scheme = SCH_RELATED_ROTATE;
         end else if (i_phase >= P3_LO && i_phase <= P3_HI) begin
            o_wb_en   = 1'b1;
            o_wb_row  = w_t3[1];
            o_wb_col  = w_t3[0];
            o_wb_swap = w_t3[1];
         end
      end
   end
endmodule

// File: rtl/pe_sched.sv
// Two-pass PE scheduler for 4x4 tile bidiagonalization; outputs decode from registered state/phase.
//   state   | meaning
//   IDLE    | waiting for start
//   RUN     | phase counter sweeps 0..2*PE_LAT+3, issuing and writing back tiles
//   DONE    | one-cycle completion pulse
module pe_sched
   import pe_pkg::*;
#(
   parameter int PE_LAT = PE_LAT_DEF,
   parameter int PH_W   = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   output logic            busy,
   output logic            done,
   output logic [1:0]      pe0_valid,
   output logic [1:0]      pe1_valid,
   output logic [1:0]      pe0_scheme,
   output logic [1:0]      pe1_scheme,
   output logic            tile_row,
   output logic            tile_col,
   output logic            op_src,
   output logic            op_swap,
   output logic            wb_en,
   output logic            wb_row,
   output logic            wb_col,
   output logic            wb_swap,
   output logic [PH_W-1:0] phase
);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * PE_LAT + 3);

   state_t          r_state;
   logic [PH_W-1:0] r_phase;
   logic            w_run;
   logic            w_issue;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_phase <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_phase <= '0;
               // abort takes priority over a coincident start
               if (start && !abort) r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (abort) begin
                  r_state <= ST_IDLE;
                  r_phase <= '0;
               end else if (r_phase == PH_LAST) begin
                  r_state <= ST_DONE;
                  r_phase <= '0;
               end else begin
                  r_phase <= r_phase + PH_W'(1);
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_phase <= '0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_phase <= '0;
            end
         endcase
      end
   end

   assign w_run     = (r_state == ST_RUN);
   assign busy      = w_run;
   assign done      = (r_state == ST_DONE);
   assign phase     = r_phase;
   assign pe0_valid = {2{w_issue}};
   assign pe1_valid = {2{w_issue}};

   pe_tile_decode #(
      .PE_LAT (PE_LAT),
      .PH_W   (PH_W)
   ) u_decode (
      .i_run        (w_run),
      .i_phase      (r_phase),
      .o_issue      (w_issue),
      .o_pe0_scheme (pe0_scheme),
      .o_pe1_scheme (pe1_scheme),
      .o_tile_row   (tile_row),
      .o_tile_col   (tile_col),
      .o_op_src     (op_src),
      .o_op_swap    (op_swap),
      .o_wb_en      (wb_en),
      .o_wb_row     (wb_row),
      .o_wb_col     (wb_col),
      .o_wb_swap    (wb_swap)
   );
endmodule

// File: tb/tb_pe_sched.sv
// Directed bench for pe_sched: PE_LAT=8 sequences (clean, re-start, abort, reset) and a PE_LAT=4 run.
module tb_pe_sched;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, abort, start4;
   int   errors = 0;
   int   checks = 0;

   logic       busy, done, tile_row, tile_col, op_src, op_swap, wb_en, wb_row, wb_col, wb_swap;
   logic [1:0] pe0_valid, pe1_valid, pe0_scheme, pe1_scheme;
   logic [4:0] phase;

   logic       busy_4, done_4, tile_row_4, tile_col_4, op_src_4, op_swap_4;
   logic       wb_en_4, wb_row_4, wb_col_4, wb_swap_4;
   logic [1:0] pe0_valid_4, pe1_valid_4, pe0_scheme_4, pe1_scheme_4;
   logic [4:0] phase_4;

   pe_sched #(.PE_LAT(8), .PH_W(5)) dut8 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .busy(busy), .done(done), .pe0_valid(pe0_valid), .pe1_valid(pe1_valid),
      .pe0_scheme(pe0_scheme), .pe1_scheme(pe1_scheme), .tile_row(tile_row), .tile_col(tile_col),
      .op_src(op_src), .op_swap(op_swap), .wb_en(wb_en), .wb_row(wb_row), .wb_col(wb_col),
      .wb_swap(wb_swap), .phase(phase)
   );

   pe_sched #(.PE_LAT(4), .PH_W(5)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .abort(1'b0),
      .busy(busy_4), .done(done_4), .pe0_valid(pe0_valid_4), .pe1_valid(pe1_valid_4),
      .pe0_scheme(pe0_scheme_4), .pe1_scheme(pe1_scheme_4), .tile_row(tile_row_4),
      .tile_col(tile_col_4), .op_src(op_src_4), .op_swap(op_swap_4), .wb_en(wb_en_4),
      .wb_row(wb_row_4), .wb_col(wb_col_4), .wb_swap(wb_swap_4), .phase(phase_4)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Full PE_LAT=8 run; cycle 1 is the first RUN cycle after the start edge.
   task automatic run_full(input string tag, input int repulse_ph);
      bit eb, ed, ei, ew;
      int ph;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 22; c++) begin
         ph = c - 1;
         eb = (c <= 20);
         ed = (c == 21);
         ei = eb && (ph <= 3 || (ph >= 8 && ph <= 11));
         ew = eb && ((ph >= 8 && ph <= 11) || (ph >= 16 && ph <= 19));
         chk({tag, "/busy"}, busy, eb);
         chk({tag, "/done"}, done, ed);
         chk({tag, "/pe0_valid"}, pe0_valid, {2{ei}});
         chk({tag, "/pe1_valid"}, pe1_valid, {2{ei}});
         chk({tag, "/wb_en"}, wb_en, ew);
         if (eb) chk({tag, "/phase"}, phase, ph);
         if (ph == 1) begin
            chk({tag, "/p1_row"}, tile_row, 0);
            chk({tag, "/p1_col"}, tile_col, 1);
            chk({tag, "/p1_s0"}, pe0_scheme, 1);
            chk({tag, "/p1_s1"}, pe1_scheme, 1);
            chk({tag, "/p1_src"}, op_src, 0);
         end
         if (ph == 10) begin
            chk({tag, "/p10_row"}, tile_row, 1);
            chk({tag, "/p10_col"}, tile_col, 0);
            chk({tag, "/p10_src"}, op_src, 1);
            chk({tag, "/p10_swap"}, op_swap, 1);
            chk({tag, "/p10_s0"}, pe0_scheme, 2);
            chk({tag, "/p10_s1"}, pe1_scheme, 3);
            chk({tag, "/p10_wbrow"}, wb_row, 1);
            chk({tag, "/p10_wbswap"}, wb_swap, 0);
         end
         if (ph == 18) begin
            chk({tag, "/p18_wbrow"}, wb_row, 1);
            chk({tag, "/p18_wbcol"}, wb_col, 0);
            chk({tag, "/p18_wbswap"}, wb_swap, 1);
            chk({tag, "/p18_s0"}, pe0_scheme, 0);
            chk({tag, "/p18_src"}, op_src, 0);
         end
         if (ph == repulse_ph) start = 1'b1;
         tick();
         start = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; start4 = 1'b0;
      repeat (3) tick();
      chk("rst/busy", busy, 0);
      chk("rst/done", done, 0);
      chk("rst/phase", phase, 0);
      rst = 1'b0;
      tick();
      chk("idle/busy", busy, 0);
      chk("idle/valid", pe0_valid, 0);
      chk("idle/busy4", busy_4, 0);

      run_full("clean", -1);
      run_full("repulse", 5);

      // abort at phase 9
      start = 1'b1; tick(); start = 1'b0;
      repeat (9) tick();
      chk("abort/pre_phase", phase, 9);
      chk("abort/pre_wb", wb_en, 1);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort/busy", busy, 0);
      chk("abort/phase", phase, 0);
      chk("abort/valid", pe0_valid, 0);
      chk("abort/wb", wb_en, 0);
      chk("abort/src", op_src, 0);
      for (int c = 0; c < 15; c++) begin
         chk("abort/no_done", done, 0);
         tick();
      end
      run_full("after_abort", -1);

      // reset at phase 12
      start = 1'b1; tick(); start = 1'b0;
      repeat (12) tick();
      chk("rstrun/pre_phase", phase, 12);
      chk("rstrun/pre_busy", busy, 1);
      rst = 1'b1; tick();
      chk("rstrun/busy", busy, 0);
      chk("rstrun/all", {done, pe0_valid, pe1_valid, pe0_scheme, pe1_scheme, tile_row, tile_col,
                         op_src, op_swap, wb_en, wb_row, wb_col, wb_swap, phase}, 0);
      rst = 1'b0; tick();
      chk("rstrun/stay_idle", busy, 0);

      // PE_LAT=4: RUN cycles 1..12, done at 13
      start4 = 1'b1; tick(); start4 = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         chk("lat4/busy", busy_4, c <= 12);
         chk("lat4/done", done_4, c == 13);
         if (c <= 12) chk("lat4/phase", phase_4, c - 1);
         if (c == 5) begin
            chk("lat4/p4_valid", pe0_valid_4, 3);
            chk("lat4/p4_wb", wb_en_4, 1);
            chk("lat4/p4_src", op_src_4, 1);
            chk("lat4/p4_s0", pe0_scheme_4, 2);
         end
         if (c == 9) begin
            chk("lat4/p8_wb", wb_en_4, 1);
            chk("lat4/p8_valid", pe0_valid_4, 0);
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
